pixel_write_sink: RTL and testbench

- Receiving end of the drawing-engine pixel-write interface (VGA_x / VGA_y / VGA_color / VGA_write) used by the screen and sprite drawers.
- The interface is fire-and-forget: the source never stalls. This block absorbs the stream in a small FIFO.
- It range-checks each pixel, converts (x,y) to a linear framebuffer address, and issues writes to a framebuffer port. That port is shared with scanout, so it applies backpressure via mem_ready.
- It also reports drops and occupancy to the master FSM.

---
 rtl/vga_pkg.sv | 16 +
 rtl/pixel_fifo.sv | 51 +++++
 rtl/pixel_write_sink.sv | 117 +++++++++++
 tb/tb_pixel_write_sink.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared drawing-engine constants: screen geometry, colour format and palette,
// plus the pixel-write sink's egress state type.
package vga_pkg;
  localparam int XSCREEN = 640;
  localparam int YSCREEN = 480;
  localparam int COLOR_W = 9;
  localparam int ADDR_W  = 19;

  // RGB 3-3-3
  localparam logic [COLOR_W-1:0] C_BLACK = 9'b000_000_000;
  localparam logic [COLOR_W-1:0] C_RED   = 9'b111_000_000;
  localparam logic [COLOR_W-1:0] C_GREEN = 9'b000_111_000;
  localparam logic [COLOR_W-1:0] C_WHITE = 9'b111_111_111;

  typedef enum logic {S_IDLE, S_HOLD} wr_state_e;
endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO; dout is the head entry, valid whenever !empty.
// A push while full is only honoured together with a pop.
module pixel_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == CW'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd];
  assign count  = r_cnt;

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/pixel_write_sink.sv
// Absorbs the fire-and-forget pixel stream, range-checks it, and issues
// framebuffer writes under mem_ready backpressure. Option: PIXEL_KEY_EN.
module pixel_write_sink
  import vga_pkg::*;
#(
  parameter int                 FIFO_DEPTH = 8,
  parameter logic [COLOR_W-1:0] KEY_COLOR  = C_BLACK
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [9:0]         VGA_x,
  input  logic [8:0]         VGA_y,
  input  logic [COLOR_W-1:0] VGA_color,
  input  logic               VGA_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic               busy,
  output logic [15:0]        drop_count,
  input  logic               clear_drops
);
  localparam int            EW     = ADDR_W + COLOR_W;
  localparam logic [10:0]   XS_LIM = 11'(XSCREEN);
  localparam logic [9:0]    YS_LIM = 10'(YSCREEN);

  wr_state_e                r_state;
  logic [ADDR_W-1:0]        r_addr;
  logic [COLOR_W-1:0]       r_data;
  logic                     r_we;
  logic [15:0]              r_drops;

  logic [ADDR_W-1:0]        w_addr;
  logic                     w_in_range, w_key, w_want, w_push, w_pop, w_drop;
  logic                     w_full, w_empty;
  logic [EW-1:0]            w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  generate
    if (XSCREEN == 640) begin : g_addr640
      assign w_addr = (ADDR_W'(VGA_y) << 9) + (ADDR_W'(VGA_y) << 7) + ADDR_W'(VGA_x);
    end else begin : g_addr_mul
      assign w_addr = ADDR_W'(32'(VGA_y) * XSCREEN + 32'(VGA_x));
    end
  endgenerate

  assign w_in_range = ({1'b0, VGA_x} < XS_LIM) && ({1'b0, VGA_y} < YS_LIM);

`ifdef PIXEL_KEY_EN
  assign w_key = (VGA_color == KEY_COLOR);
`else
  assign w_key = 1'b0;
`endif

  // Egress drains the head whenever the output slot is free or being freed.
  assign w_pop  = !w_empty && (r_state == S_IDLE || mem_ready);
  assign w_want = VGA_write && w_in_range && !w_key;
  assign w_push = w_want && (!w_full || w_pop);
  assign w_drop = VGA_write && (!w_in_range || (w_want && w_full && !w_pop));

  pixel_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clock  (Clock),
    .Resetn (Resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    ({w_addr, VGA_color}),
    .dout   (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {r_addr, r_data} <= w_head;
            r_we    <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (mem_ready) begin
            if (!w_empty) begin
              {r_addr, r_data} <= w_head;
            end else begin
              r_we    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                        r_drops <= '0;
    else if (clear_drops)               r_drops <= '0;
    else if (w_drop && r_drops != '1)   r_drops <= r_drops + 16'd1;
  end

  assign mem_addr   = r_addr;
  assign mem_data   = r_data;
  assign mem_we     = r_we;
  assign drop_count = r_drops;
  assign busy       = (w_count != '0) | r_we;
endmodule

// File: tb/tb_pixel_write_sink.sv
// Bench for pixel_write_sink: vector table, hand-written corner sequences and
// random traffic against a queue-level reference model.
module tb_pixel_write_sink;
  localparam int DEPTH = 8;
`ifdef PIXEL_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic        Clock = 1'b0, Resetn = 1'b0;
  logic [9:0]  VGA_x = '0;
  logic [8:0]  VGA_y = '0;
  logic [8:0]  VGA_color = '0;
  logic        VGA_write = 1'b0, mem_ready = 1'b1, clear_drops = 1'b0;
  logic [18:0] mem_addr;
  logic [8:0]  mem_data;
  logic        mem_we, busy;
  logic [15:0] drop_count;

  pixel_write_sink dut (
    .Clock(Clock), .Resetn(Resetn), .VGA_x(VGA_x), .VGA_y(VGA_y),
    .VGA_color(VGA_color), .VGA_write(VGA_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready), .busy(busy),
    .drop_count(drop_count), .clear_drops(clear_drops)
  );

  always #5 Clock = ~Clock;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a queue of accepted pixels plus the one being presented.
  typedef struct { int addr; int color; } pix_t;
  pix_t mq[$];
  pix_t m_out;
  bit   m_out_v = 0;
  int   m_drops = 0;
  int   wr_cnt = 0, last_addr = 0, last_color = 0;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mq.delete();
      m_out_v = 0;
      m_drops = 0;
    end else begin
      bit pop_ok, drop, push;
      if (mem_we && mem_ready) begin
        wr_cnt++;
        last_addr  = int'(mem_addr);
        last_color = int'(mem_data);
      end
      pop_ok = (mq.size() > 0) && (!m_out_v || mem_ready);
      if (pop_ok) begin
        m_out   = mq.pop_front();
        m_out_v = 1;
      end else if (m_out_v && mem_ready) begin
        m_out_v = 0;
      end
      drop = 0;
      push = 0;
      if (VGA_write) begin
        if (int'(VGA_x) >= 640 || int'(VGA_y) >= 480) drop = 1;
        else if (KEY_EN && VGA_color == 9'h000)       drop = 0;
        else if (mq.size() < DEPTH)                   push = 1;
        else                                          drop = 1;
      end
      if (push) mq.push_back('{int'(VGA_y) * 640 + int'(VGA_x), int'(VGA_color)});
      if (clear_drops)                   m_drops = 0;
      else if (drop && m_drops < 65535)  m_drops++;
    end
  end

  always @(negedge Clock) begin
    if (Resetn) begin
      chk("mdl_we", mem_we, m_out_v);
      if (m_out_v) begin
        chk("mdl_addr", mem_addr, m_out.addr);
        chk("mdl_data", mem_data, m_out.color);
      end
      chk("mdl_busy", busy, (mq.size() != 0) || m_out_v);
      chk("mdl_drops", drop_count, m_drops);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send(input int x, input int y, input int c);
    VGA_x = 10'(x); VGA_y = 9'(y); VGA_color = 9'(c); VGA_write = 1'b1;
    cyc(1);
  endtask

  task automatic idle();
    VGA_write = 1'b0;
  endtask

  typedef struct { int x; int y; int c; bit wr; int addr; } vec_t;
  vec_t vt[9];

  int w0, d0, a0;

  initial begin
    vt[0] = '{0,   0,   'h1FF, 1, 0};
    vt[1] = '{639, 0,   'h038, 1, 639};
    vt[2] = '{0,   479, 'h007, 1, 306560};
    vt[3] = '{639, 479, 'h1C0, 1, 307199};
    vt[4] = '{640, 479, 'h1C0, 0, 0};
    vt[5] = '{639, 480, 'h1C0, 0, 0};
    vt[6] = '{1023, 511, 'h0AA, 0, 0};
    vt[7] = '{10,  2,   'h1C0, 1, 1290};
    vt[8] = '{320, 240, 'h0AA, 1, 153920};

    cyc(2);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drops", drop_count, 0);
    Resetn = 1'b1;
    cyc(1);

    // single pixel latency
    send(10, 2, 'h1C0);
    idle();
    chk("single_we_E0", mem_we, 0);
    cyc(1);
    chk("single_we_E1", mem_we, 1);
    chk("single_addr", mem_addr, 1290);
    chk("single_data", mem_data, 'h1C0);
    cyc(1);
    chk("single_we_E2", mem_we, 0);
    chk("single_busy_E2", busy, 0);

    // vector table
    foreach (vt[i]) begin
      w0 = wr_cnt; d0 = int'(drop_count);
      send(vt[i].x, vt[i].y, vt[i].c);
      idle();
      cyc(3);
      chk("vec_writes", wr_cnt - w0, vt[i].wr);
      chk("vec_drops", int'(drop_count) - d0, !vt[i].wr);
      if (vt[i].wr) begin
        chk("vec_addr", last_addr, vt[i].addr);
        chk("vec_color", last_color, vt[i].c);
      end
    end

    // 40-pixel burst, back-to-back
    w0 = wr_cnt; d0 = int'(drop_count);
    for (int i = 0; i < 40; i++) send(100 + i, 50, 1 + i);
    idle();
    cyc(1);
    chk("burst_busy_last", busy, 1);
    cyc(1);
    chk("burst_writes", wr_cnt - w0, 40);
    chk("burst_busy_fall", busy, 0);
    chk("burst_drops", int'(drop_count) - d0, 0);

    // stall: 12 pixels into 1 output slot + 8 entries
    mem_ready = 1'b0;
    w0 = wr_cnt; d0 = int'(drop_count);
    for (int i = 0; i < 12; i++) send(i, 7, 'h100 + i);
    idle();
    cyc(1);
    chk("stall_drops", int'(drop_count) - d0, 3);
    chk("stall_we", mem_we, 1);
    chk("stall_addr", mem_addr, 7 * 640);
    cyc(5);
    chk("stall_addr_hold", mem_addr, 7 * 640);
    chk("stall_data_hold", mem_data, 'h100);
    mem_ready = 1'b1;
    cyc(10);
    chk("stall_writes", wr_cnt - w0, 9);
    chk("stall_busy", busy, 0);

    // out of range, then clear coinciding with an overflow drop
    w0 = wr_cnt; d0 = int'(drop_count);
    send(640, 0, 'h1C0);
    send(0, 480, 'h1C0);
    idle();
    cyc(3);
    chk("oor_drops", int'(drop_count) - d0, 2);
    chk("oor_writes", wr_cnt - w0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(i, 9, 'h038);
    clear_drops = 1'b1;
    send(9, 9, 'h038);
    clear_drops = 1'b0;
    idle();
    chk("clear_vs_drop", drop_count, 0);
    mem_ready = 1'b1;
    cyc(12);

    // async reset mid-burst
    send(700, 0, 'h1C0);
    for (int i = 0; i < 4; i++) send(200 + i, 3, 'h1FF);
    #2 Resetn = 1'b0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_drops", drop_count, 0);
    chk("arst_addr", mem_addr, 0);
    idle();
    cyc(1);
    Resetn = 1'b1;
    cyc(1);
    w0 = wr_cnt;
    send(5, 5, 'h1FF);
    idle();
    cyc(3);
    chk("post_rst_writes", wr_cnt - w0, 1);
    chk("post_rst_addr", last_addr, 3205);

    // key colour
    w0 = wr_cnt; d0 = int'(drop_count);
    for (int i = 0; i < 10; i++) send(i, 10, (i % 2) ? 'h1C0 : 'h000);
    idle();
    cyc(4);
    chk("key_writes", wr_cnt - w0, KEY_EN ? 5 : 10);
    chk("key_drops", int'(drop_count) - d0, 0);

    // random traffic with stall phases
    for (int i = 0; i < 3000; i++) begin
      VGA_write   = ($urandom % 4) != 0;
      VGA_x       = 10'($urandom % 700);
      VGA_y       = 9'($urandom % 520);
      VGA_color   = (($urandom % 4) == 0) ? 9'h000 : 9'($urandom);
      a0          = (i / 200) % 3;
      mem_ready   = (a0 == 0) ? 1'b1 : (a0 == 1) ? (($urandom % 3) != 0) : (($urandom % 8) == 0);
      clear_drops = ($urandom % 150) == 0;
      cyc(1);
    end
    idle();
    clear_drops = 1'b0;
    mem_ready = 1'b1;
    cyc(20);
    chk("rand_drain_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
